// File: rtl/axi4_lite_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_reg_pkg
// Description : Shared types and helpers for the AXI4-Lite register read
//               back-end: FSM state encoding, address region encoding,
//               response constants and the region decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DECODE   = 2'd1,
      ST_EXT_WAIT = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      REG_LOCAL   = 2'd0,
      REG_COUNTER = 2'd1,
      REG_EXT     = 2'd2,
      REG_HOLE    = 2'd3
   } region_e;

   localparam logic RESP_OKAY = 1'b1;
   localparam logic RESP_ERR  = 1'b0;

   // Classify a word-aligned byte address. Regions are checked in address
   // order; anything below ext_base that is neither local nor counter space
   // is the unmapped hole.
   function automatic region_e decode_region(
      input logic [31:0] addr,
      input logic [31:0] num_regs,
      input logic [31:0] cnt_base,
      input logic [31:0] num_counters,
      input logic [31:0] ext_base
   );
      region_e r;
      if (addr < (num_regs << 2))
         r = REG_LOCAL;
      else if ((addr >= cnt_base) && (addr < (cnt_base + (num_counters << 3))))
         r = REG_COUNTER;
      else if (addr >= ext_base)
         r = REG_EXT;
      else
         r = REG_HOLE;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_counter_snapshot.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_counter_snapshot
// Description : Shadow registers holding the upper 32 bits of each 64-bit
//               counter, captured in the same clock as the low word is read
//               so a low/high read pair forms one coherent sample.
// Ports       : clk, rst_n (async, active-low)
//               counters    - live counter values, 64 bits per counter
//               load        - capture counters[index][63:32] into shadow
//               index       - selected counter
//               shadow_word - current shadow of the selected counter
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_counter_snapshot
   import axi4_lite_reg_pkg::*;
#(
   parameter int NUM_COUNTERS = 4,
   parameter int IDX_W        = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [64*NUM_COUNTERS-1:0] counters,
   input  logic                      load,
   input  logic [IDX_W-1:0]          index,
   output logic [31:0]               shadow_word
);

   logic [31:0] shadow_q [NUM_COUNTERS];
   logic [31:0] shadow_d [NUM_COUNTERS];

   always_comb begin
      shadow_word = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         shadow_d[i] = shadow_q[i];
         if (index == IDX_W'(i)) begin
            shadow_word = shadow_q[i];
            if (load)
               shadow_d[i] = counters[64*i+32 +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_COUNTERS; i++)
            shadow_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_COUNTERS; i++)
            shadow_q[i] <= shadow_d[i];
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_reg_read_backend.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_reg_read_backend
// Description : Register read back-end behind an AXI4-Lite slave read
//               channel. Decodes the latched address into local registers,
//               snapshotted 64-bit counters, an external wait-state port or
//               an unmapped hole, and holds read_value / read_response /
//               read_ready until read_req drops.
// Ports       : clk, rst_n (async, active-low)
//               read_req, read_addr        - request from the read channel
//               read_ready, read_response, read_value - result to channel
//               reg_values                 - local register contents
//               counters                   - live 64-bit counters
//               ext_req, ext_addr          - external access request
//               ext_ack, ext_ok, ext_data  - external completion
// Option      : AXI_REG_READ_TIMEOUT_EN - bound the external wait to
//               TIMEOUT_CYCLES cycles, then answer SLVERR with zero data.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_read_backend
   import axi4_lite_reg_pkg::*;
#(
   parameter int ADDR_WIDTH     = 7,
   parameter int NUM_REGS       = 8,
   parameter int NUM_COUNTERS   = 4,
   parameter int CNT_BASE       = 32,
   parameter int EXT_BASE       = 96,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       read_req,
   input  logic [ADDR_WIDTH-1:0]      read_addr,
   output logic                       read_ready,
   output logic                       read_response,
   output logic [31:0]                read_value,
   input  logic [32*NUM_REGS-1:0]     reg_values,
   input  logic [64*NUM_COUNTERS-1:0] counters,
   output logic                       ext_req,
   output logic [ADDR_WIDTH-1:0]      ext_addr,
   input  logic                       ext_ack,
   input  logic                       ext_ok,
   input  logic [31:0]                ext_data
);

   localparam int DW_W = ADDR_WIDTH - 3;   // doubleword (8-byte) index width

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  read_ready_q, read_ready_d;
   logic                  read_response_q, read_response_d;
   logic [31:0]           read_value_q, read_value_d;
   logic                  ext_req_q, ext_req_d;
   logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
`ifdef AXI_REG_READ_TIMEOUT_EN
   logic [7:0]            wait_cnt_q, wait_cnt_d;
`endif

   region_e               region;
   logic [DW_W-1:0]       cnt_idx;
   logic [31:0]           local_word;
   logic [31:0]           counter_lo;
   logic [31:0]           shadow_word;
   logic                  cnt_load;

   assign region = decode_region(32'(addr_q), 32'(NUM_REGS), 32'(CNT_BASE),
                                 32'(NUM_COUNTERS), 32'(EXT_BASE));

   // The counter base is 8-aligned, so the counter number is the doubleword
   // offset and addr_q[2] alone selects the low or high half.
   assign cnt_idx = addr_q[ADDR_WIDTH-1:3] - DW_W'(CNT_BASE / 8);

   always_comb begin
      local_word = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (addr_q[ADDR_WIDTH-1:2] == (ADDR_WIDTH-2)'(i))
            local_word = reg_values[32*i +: 32];
   end

   always_comb begin
      counter_lo = '0;
      for (int i = 0; i < NUM_COUNTERS; i++)
         if (cnt_idx == DW_W'(i))
            counter_lo = counters[64*i +: 32];
   end

   axi4_lite_counter_snapshot #(
      .NUM_COUNTERS (NUM_COUNTERS),
      .IDX_W        (DW_W)
   ) u_snapshot (
      .clk         (clk),
      .rst_n       (rst_n),
      .counters    (counters),
      .load        (cnt_load),
      .index       (cnt_idx),
      .shadow_word (shadow_word)
   );

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      read_ready_d    = read_ready_q;
      read_response_d = read_response_q;
      read_value_d    = read_value_q;
      ext_req_d       = ext_req_q;
      ext_addr_d      = ext_addr_q;
      cnt_load        = 1'b0;
`ifdef AXI_REG_READ_TIMEOUT_EN
      wait_cnt_d      = wait_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (read_req) begin
               addr_d  = {read_addr[ADDR_WIDTH-1:2], 2'b00};
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (!read_req) begin
               state_d = ST_IDLE;
            end else begin
               case (region)
                  REG_LOCAL: begin
                     read_value_d    = local_word;
                     read_response_d = RESP_OKAY;
                     read_ready_d    = 1'b1;
                     state_d         = ST_DONE;
                  end
                  REG_COUNTER: begin
                     if (!addr_q[2]) begin
                        read_value_d = counter_lo;
                        cnt_load     = 1'b1;
                     end else begin
                        read_value_d = shadow_word;
                     end
                     read_response_d = RESP_OKAY;
                     read_ready_d    = 1'b1;
                     state_d         = ST_DONE;
                  end
                  REG_EXT: begin
                     ext_req_d  = 1'b1;
                     ext_addr_d = addr_q - ADDR_WIDTH'(EXT_BASE);
`ifdef AXI_REG_READ_TIMEOUT_EN
                     wait_cnt_d = '0;
`endif
                     state_d    = ST_EXT_WAIT;
                  end
                  default: begin
                     read_value_d    = '0;
                     read_response_d = RESP_ERR;
                     read_ready_d    = 1'b1;
                     state_d         = ST_DONE;
                  end
               endcase
            end
         end
         ST_EXT_WAIT: begin
            if (!read_req) begin
               ext_req_d = 1'b0;
               state_d   = ST_IDLE;
            end else if (ext_ack) begin
               read_value_d    = ext_data;
               read_response_d = ext_ok;
               read_ready_d    = 1'b1;
               ext_req_d       = 1'b0;
               state_d         = ST_DONE;
            end
`ifdef AXI_REG_READ_TIMEOUT_EN
            else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               read_value_d    = '0;
               read_response_d = RESP_ERR;
               read_ready_d    = 1'b1;
               ext_req_d       = 1'b0;
               state_d         = ST_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
`endif
         end
         ST_DONE: begin
            if (!read_req) begin
               read_ready_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         read_ready_q    <= 1'b0;
         read_response_q <= 1'b0;
         read_value_q    <= '0;
         ext_req_q       <= 1'b0;
         ext_addr_q      <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         read_ready_q    <= read_ready_d;
         read_response_q <= read_response_d;
         read_value_q    <= read_value_d;
         ext_req_q       <= ext_req_d;
         ext_addr_q      <= ext_addr_d;
      end
   end

`ifdef AXI_REG_READ_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt_q <= '0;
      else
         wait_cnt_q <= wait_cnt_d;
   end
`endif

   assign read_ready    = read_ready_q;
   assign read_response = read_response_q;
   assign read_value    = read_value_q;
   assign ext_req       = ext_req_q;
   assign ext_addr      = ext_addr_q;

endmodule
`default_nettype wire
